// File: rtl/ex_stage_if.sv
// Handshake and operand/result bundle between ID/EX and the execute stage.
// The master side feeds operands in and consumes results toward EX/MEM.
interface ex_stage_if;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [2:0]  op_i;
    logic        control_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data3_i;
    logic [31:0] IR_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic [31:0] store_data_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic [31:0] IR_o;

    modport master (
        output valid_i, flush_i, op_i, control_i,
        output data1_i, data2_i, data3_i, IR_i,
        input  ready_o, valid_o, result_o, store_data_o,
        input  branch_taken_o, branch_target_o, IR_o
    );

    modport slave (
        input  valid_i, flush_i, op_i, control_i,
        input  data1_i, data2_i, data3_i, IR_i,
        output ready_o, valid_o, result_o, store_data_o,
        output branch_taken_o, branch_target_o, IR_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ADD/SLL/BGE and a 32-step shift-add MUL.
// Results, branch resolution and store data are registered toward EX/MEM.
module ex_stage (
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_BGE = 3'b011;
    localparam int         MUL_ITER = 32;
    localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic        valid_q;
    logic [31:0] result_q;
    logic [31:0] store_q;
    logic        taken_q;
    logic [31:0] target_q;
    logic [31:0] ir_q;

    logic [31:0] opb;
    logic        accept;
    logic [31:0] alu_d;
    logic        taken_d;
    logic [31:0] acc_d;

    assign opb    = bus.control_i ? bus.data2_i : bus.data3_i;
    assign accept = bus.valid_i && (state_q == IDLE) && !bus.flush_i;
    assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu_d   = '0;
        taken_d = 1'b0;
        unique case (1'b1)
            (bus.op_i == OP_ADD): alu_d = bus.data1_i + opb;
            (bus.op_i == OP_SLL): alu_d = bus.data1_i << opb[4:0];
            (bus.op_i == OP_BGE):
                taken_d = $signed(bus.data1_i) >= $signed(opb);
            default: begin
                alu_d   = '0;
                taken_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
            ir_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ir_q     <= bus.IR_i;
                        store_q  <= bus.data3_i;
                        target_q <= bus.data3_i;
                        if (bus.op_i == OP_MUL) begin
                            state_q  <= MUL;
                            acc_q    <= '0;
                            mcand_q  <= bus.data1_i;
                            mplier_q <= opb;
                            cnt_q    <= '0;
                        end else begin
                            result_q <= alu_d;
                            taken_q  <= taken_d;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Flush wins over a completion on the same edge.
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 5'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= IDLE;
                            cnt_q    <= '0;
                            result_q <= acc_d;
                            taken_q  <= 1'b0;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o         = (state_q == IDLE);
    assign bus.valid_o         = valid_q;
    assign bus.result_o        = result_q;
    assign bus.store_data_o    = store_q;
    assign bus.branch_taken_o  = taken_q;
    assign bus.branch_target_o = target_q;
    assign bus.IR_o            = ir_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, random ops vs. arithmetic model,
// and hand sequences for MUL stall, flush and reset corners.
module tb_ex_stage;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_BGE = 3'b011;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_stage_if bus ();

    ex_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        ctrl;
        logic [31:0] a;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [31:0] res;
        logic        tkn;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic c,
                                  input logic [31:0] a, d2, d3,
                                  output logic [31:0] r,
                                  output logic t);
        logic [31:0] b;
        b = c ? d2 : d3;
        r = '0;
        t = 1'b0;
        case (op)
            OP_ADD: r = a + b;
            OP_MUL: r = a * b;
            OP_SLL: r = a << b[4:0];
            OP_BGE: t = $signed(a) >= $signed(b);
            default: r = '0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic c,
                         input logic [31:0] a, d2, d3, ir);
        bus.op_i      = op;
        bus.control_i = c;
        bus.data1_i   = a;
        bus.data2_i   = d2;
        bus.data3_i   = d3;
        bus.IR_i      = ir;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic c, input logic [31:0] a, d2, d3,
                          input logic [31:0] ir, input logic [31:0] er,
                          input logic et);
        int n;
        @(negedge clk);
        drive(op, c, a, d2, d3, ir);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        n = 0;
        while (!bus.valid_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), (op == OP_MUL) ? 32'd32 : 32'd0);
        chk({tag, " result"}, bus.result_o, er);
        chk({tag, " taken"}, 32'(bus.branch_taken_o), 32'(et));
        chk({tag, " IR"}, bus.IR_o, ir);
        chk({tag, " store"}, bus.store_data_o, d3);
        chk({tag, " target"}, bus.branch_target_o, d3);
        chk({tag, " ready"}, 32'(bus.ready_o), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid_o"}, 32'(bus.valid_o), 32'd0);
        chk({tag, " result_o"}, bus.result_o, 32'd0);
        chk({tag, " store"}, bus.store_data_o, 32'd0);
        chk({tag, " taken"}, 32'(bus.branch_taken_o), 32'd0);
        chk({tag, " target"}, bus.branch_target_o, 32'd0);
        chk({tag, " IR_o"}, bus.IR_o, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        et;
        logic [2:0]  rop;
        logic        rc;
        logic [31:0] ra, rd2, rd3;
        int          stray;

        checks = 0;
        errors = 0;
        vecs[0]  = '{OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h2,
                     32'h1, 1'b0};
        vecs[1]  = '{OP_SLL, 1'b1, 32'h3, 32'h24, 32'h0,
                     32'h30, 1'b0};
        vecs[2]  = '{OP_BGE, 1'b1, 32'hFFFF_FFFE, 32'h1, 32'h40,
                     32'h0, 1'b0};
        vecs[3]  = '{OP_BGE, 1'b1, 32'h5, 32'h5, 32'h40,
                     32'h0, 1'b1};
        vecs[4]  = '{3'b111, 1'b1, 32'h123, 32'h456, 32'h789,
                     32'h0, 1'b0};
        vecs[5]  = '{OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'hAB,
                     32'h8000_0000, 1'b0};
        vecs[6]  = '{OP_SLL, 1'b0, 32'h1, 32'h0, 32'hFFFF_FFFF,
                     32'h8000_0000, 1'b0};
        vecs[7]  = '{OP_BGE, 1'b0, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000,
                     32'h0, 1'b1};
        vecs[8]  = '{OP_BGE, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h44,
                     32'h0, 1'b0};
        vecs[9]  = '{3'b100, 1'b1, 32'h1, 32'h2, 32'h3,
                     32'h0, 1'b0};
        vecs[10] = '{OP_ADD, 1'b0, 32'h10, 32'hFFFF, 32'h20,
                     32'h30, 1'b0};

        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(bus.ready_o), 32'd1);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].ctrl,
                   vecs[i].a, vecs[i].d2, vecs[i].d3,
                   32'hA000_0000 + 32'(i), vecs[i].res, vecs[i].tkn);
        @(posedge clk);
        #1;
        chk("valid_o one-cycle pulse", 32'(bus.valid_o), 32'd0);

        // MUL stall with an ADD held on the input during the stall
        @(negedge clk);
        drive(OP_MUL, 1'b0, 32'h1234_5678, 32'h0, 32'h9ABC_DEF0,
              32'hBEEF_0001);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        drive(OP_ADD, 1'b1, 32'h1, 32'h2, 32'h77, 32'hBEEF_0002);
        stray = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.valid_o) stray++;
        end
        chk("mul stall ready/valid low", 32'(stray), 32'd0);
        @(posedge clk);
        #1;
        chk("mul N+32 valid", 32'(bus.valid_o), 32'd1);
        chk("mul N+32 result", bus.result_o, 32'h242D_2080);
        chk("mul N+32 IR", bus.IR_o, 32'hBEEF_0001);
        chk("mul N+32 ready", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        chk("held add valid", 32'(bus.valid_o), 32'd1);
        chk("held add result", bus.result_o, 32'h3);
        chk("held add IR", bus.IR_o, 32'hBEEF_0002);
        @(posedge clk);
        #1;
        chk("held add pulse end", 32'(bus.valid_o), 32'd0);

        // Flush mid-MUL at edge N+10
        run_op("pre-flush", OP_ADD, 1'b1, 32'h50, 32'h5, 32'h0,
               32'hC000_0001, 32'h55, 1'b0);
        @(negedge clk);
        drive(OP_MUL, 1'b1, 32'h3, 32'h7, 32'h0, 32'hC000_0002);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        chk("flush ready", 32'(bus.ready_o), 32'd1);
        chk("flush valid", 32'(bus.valid_o), 32'd0);
        chk("flush result kept", bus.result_o, 32'h55);
        run_op("post-flush", OP_ADD, 1'b0, 32'h100, 32'h0, 32'h23,
               32'hC000_0003, 32'h123, 1'b0);
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) stray++;
        end
        chk("no late completion after flush", 32'(stray), 32'd0);

        // Flush in IDLE suppresses the accept
        @(negedge clk);
        drive(OP_ADD, 1'b1, 32'h9, 32'h9, 32'h9, 32'hDEAD_0000);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("idle flush valid", 32'(bus.valid_o), 32'd0);
        chk("idle flush IR kept", bus.IR_o, 32'hC000_0003);
        chk("idle flush result kept", bus.result_o, 32'h123);

        // Random ops against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            rc  = 1'($urandom);
            ra  = $urandom;
            rd2 = $urandom;
            rd3 = $urandom;
            if (i % 5 == 0) ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            model(rop, rc, ra, rd2, rd3, er, et);
            run_op($sformatf("rnd%0d", i), rop, rc, ra, rd2, rd3,
                   $urandom, er, et);
        end

        // Asynchronous reset mid-cycle with nonzero outputs
        run_op("pre-reset", OP_BGE, 1'b1, 32'h1, 32'h1, 32'h99,
               32'hF000_0001, 32'h0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("mid-cycle reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after mid reset", 32'(bus.ready_o), 32'd1);

        // Reset during a MUL aborts it
        @(negedge clk);
        drive(OP_MUL, 1'b1, 32'h5, 32'h6, 32'h0, 32'hF000_0002);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mul reset ready", 32'(bus.ready_o), 32'd1);
        chk("mul reset IR", bus.IR_o, 32'h0);
        #2;
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) stray++;
        end
        chk("no completion after reset", 32'(stray), 32'd0);
        chk("result after aborted mul", bus.result_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
